// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 decipher controller.
package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } dec_state_e;

    localparam int unsigned AES128_ROUNDS = 10;
    localparam int unsigned NUM_RKEYS     = AES128_ROUNDS + 1;
    localparam int unsigned DEC_LATENCY   = 53;
    localparam int unsigned RKEY_W        = 128;

endpackage

// File: rtl/aes_decipher_ctrl_rkey_store.sv
// Round-key register file with per-entry written mask and combinational read port.
module aes_rkey_store #(
    parameter int unsigned NUM_RKEYS = aes_ctrl_pkg::NUM_RKEYS
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         we,
    input  logic [3:0]   addr,
    input  logic [127:0] data,
    input  logic         clear,
    input  logic [3:0]   rd_addr,
    output logic [127:0] rd_data,
    output logic         all_valid
);
    import aes_ctrl_pkg::*;

    localparam logic [3:0] LAST_IDX = 4'(NUM_RKEYS - 1);

    logic [RKEY_W-1:0]    mem [NUM_RKEYS];
    logic [NUM_RKEYS-1:0] mask;
    logic                 wr_ok;

    assign wr_ok = we && (addr <= LAST_IDX);

    // Clear wins over a same-cycle write: neither the mask bit nor the entry is updated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask <= '0;
            for (int unsigned i = 0; i < NUM_RKEYS; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            mask <= '0;
        end else if (wr_ok) begin
            mem[addr]  <= data;
            mask[addr] <= 1'b1;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_addr <= LAST_IDX) begin
            rd_data = mem[rd_addr];
        end
    end

    assign all_valid = &mask;

endmodule

// File: rtl/aes_decipher_ctrl.sv
// Valid/ready wrapper sequencing one external AES-128 decipher core, with round-key store.
module aes_decipher_ctrl #(
    parameter int unsigned NUM_RKEYS = aes_ctrl_pkg::NUM_RKEYS,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             key_we,
    input  logic [3:0]       key_addr,
    input  logic [127:0]     key_data,
    input  logic             key_clear,
    output logic             keys_valid,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_block,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_block,
    output logic             core_next,
    output logic [127:0]     core_block,
    input  logic [3:0]       core_round,
    output logic [127:0]     core_round_key,
    input  logic             core_ready,
    input  logic [127:0]     core_new_block,
    output logic             busy,
    output logic [CNT_W-1:0] blocks_done
);
    import aes_ctrl_pkg::*;

    dec_state_e state, state_nxt;
    logic       accept;
    logic       capture;
    logic       drain;

    aes_rkey_store #(
        .NUM_RKEYS(NUM_RKEYS)
    ) u_rkey_store (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (key_we && (state == ST_IDLE)),
        .addr     (key_addr),
        .data     (key_data),
        .clear    (key_clear),
        .rd_addr  (core_round),
        .rd_data  (core_round_key),
        .all_valid(keys_valid)
    );

    assign in_ready = (state == ST_IDLE) && keys_valid && core_ready;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;
    // A result may only enter the output register if it is empty or draining this cycle.
    assign capture  = (state == ST_WAIT) && core_ready && (!out_valid || out_ready);
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        core_next = 1'b0;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_START;
            ST_START: begin
                core_next = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT:  if (capture) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_block  <= '0;
            out_block   <= '0;
            out_valid   <= 1'b0;
            blocks_done <= '0;
        end else begin
            if (accept) begin
                core_block <= in_block;
            end
            if (capture) begin
                out_block <= core_new_block;
                out_valid <= 1'b1;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
            if (drain) begin
                blocks_done <= blocks_done + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_aes_decipher_ctrl.sv
// Directed bench for aes_decipher_ctrl with a behavioural AES-128 inverse-cipher core attached.
module tb_aes_decipher_ctrl;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         key_we, key_clear;
    logic [3:0]   key_addr;
    logic [127:0] key_data;
    logic         keys_valid, in_valid, in_ready, out_valid, out_ready;
    logic [127:0] in_block, out_block, core_block, core_round_key, core_new_block;
    logic         core_next, core_ready, busy;
    logic [3:0]   core_round;
    logic [15:0]  blocks_done;

    logic         keys_valid4, in_ready4, out_valid4, core_next4, busy4;
    logic [127:0] out_block4, core_block4, core_round_key4;
    logic [3:0]   blocks_done4;

    always #5 clk = ~clk;

    aes_decipher_ctrl dut (
        .clk(clk), .reset_n(reset_n), .key_we(key_we), .key_addr(key_addr),
        .key_data(key_data), .key_clear(key_clear), .keys_valid(keys_valid),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .core_next(core_next), .core_block(core_block), .core_round(core_round),
        .core_round_key(core_round_key), .core_ready(core_ready),
        .core_new_block(core_new_block), .busy(busy), .blocks_done(blocks_done)
    );

    aes_decipher_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .key_we(key_we), .key_addr(key_addr),
        .key_data(key_data), .key_clear(key_clear), .keys_valid(keys_valid4),
        .in_valid(in_valid), .in_ready(in_ready4), .in_block(in_block),
        .out_valid(out_valid4), .out_ready(out_ready), .out_block(out_block4),
        .core_next(core_next4), .core_block(core_block4), .core_round(core_round),
        .core_round_key(core_round_key4), .core_ready(core_ready),
        .core_new_block(core_new_block), .busy(busy4), .blocks_done(blocks_done4)
    );

    // ---------------- AES helpers ----------------
    logic [7:0]   sbox [256];
    logic [7:0]   inv_sbox [256];
    logic [127:0] rks [11];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00, x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
        return (a << n) | (a >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int unsigned x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00, s;
            for (int unsigned y = 1; y < 256; y++)
                if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[x] = s;
            inv_sbox[s] = 8'(x);
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int unsigned i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int unsigned i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int unsigned r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] inv_shift(input logic [127:0] s);
        logic [127:0] o;
        for (int unsigned rr = 0; rr < 4; rr++)
            for (int unsigned c = 0; c < 4; c++)
                o[127-8*(rr+4*c) -: 8] = s[127-8*(rr+4*((c+4-rr)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub(input logic [127:0] s);
        logic [127:0] o;
        for (int unsigned i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox[s[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int unsigned c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {
                gm(a0,8'h0e) ^ gm(a1,8'h0b) ^ gm(a2,8'h0d) ^ gm(a3,8'h09),
                gm(a0,8'h09) ^ gm(a1,8'h0e) ^ gm(a2,8'h0b) ^ gm(a3,8'h0d),
                gm(a0,8'h0d) ^ gm(a1,8'h09) ^ gm(a2,8'h0e) ^ gm(a3,8'h0b),
                gm(a0,8'h0b) ^ gm(a1,8'h0d) ^ gm(a2,8'h09) ^ gm(a3,8'h0e)};
        end
        return o;
    endfunction

    function automatic logic [127:0] ref_dec(input logic [127:0] ct);
        logic [127:0] s = ct ^ rks[10];
        for (int r = 9; r >= 1; r--) s = inv_mix(inv_sub(inv_shift(s)) ^ rks[r]);
        return inv_sub(inv_shift(s)) ^ rks[0];
    endfunction

    // ---------------- external core model: ready again 51 edges after start ----------------
    logic [3:0]   crnd, rk_idx;
    logic         rk_ovr = 1'b0;
    logic         cbusy, ractive;
    logic [5:0]   ccnt;
    logic [127:0] cst;

    assign core_round = rk_ovr ? rk_idx : crnd;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_ready <= 1'b1; cbusy <= 1'b0; ractive <= 1'b0; ccnt <= '0;
            crnd <= '0; cst <= '0; core_new_block <= '0;
        end else if (core_next) begin
            core_ready <= 1'b0; cbusy <= 1'b1; ractive <= 1'b1; ccnt <= 6'd1;
            crnd <= 4'd10; cst <= core_block;
        end else if (cbusy) begin
            ccnt <= ccnt + 6'd1;
            if (ractive) begin
                if (crnd == 4'd10)     cst <= cst ^ core_round_key;
                else if (crnd != 4'd0) cst <= inv_mix(inv_sub(inv_shift(cst)) ^ core_round_key);
                else                   cst <= inv_sub(inv_shift(cst)) ^ core_round_key;
                if (crnd == 4'd0) ractive <= 1'b0;
                else              crnd <= crnd - 4'd1;
            end
            if (ccnt == 6'd51) begin
                core_ready <= 1'b1; cbusy <= 1'b0; core_new_block <= cst;
            end
        end
    end

    // ---------------- checking ----------------
    int unsigned n_pass = 0, n_total = 0, ndel = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic wr_key(input logic [3:0] a, input logic [127:0] d);
        @(negedge clk); key_we = 1'b1; key_addr = a; key_data = d;
        @(negedge clk); key_we = 1'b0;
    endtask

    task automatic load_keys(input logic [127:0] key);
        expand(key);
        @(negedge clk); key_clear = 1'b1;
        @(negedge clk); key_clear = 1'b0;
        for (int unsigned i = 0; i < 11; i++) wr_key(4'(i), rks[i]);
    endtask

    task automatic send(input string nm, input logic [127:0] b);
        int unsigned n = 0;
        @(negedge clk); in_block = b; in_valid = 1'b1;
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        chk({nm, "_accept"}, in_ready, 1'b1);
        @(posedge clk); #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int unsigned lat);
        lat = 0;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic recv(input string nm, input logic [127:0] exp);
        int unsigned n = 0;
        @(negedge clk);
        while (!out_valid && n < 300) begin @(negedge clk); n++; end
        chk({nm, "_valid"}, out_valid, 1'b1);
        chk({nm, "_block"}, out_block, exp);
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        ndel++;
    endtask

    typedef struct { logic [127:0] key; logic [127:0] ct; logic [127:0] pt; } vec_t;
    typedef struct { logic [3:0] idx; logic [127:0] exp; } rkv_t;

    localparam logic [127:0] KC1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    vec_t vecs [4];
    rkv_t rkv  [5];

    initial begin
        int unsigned lat, base;
        logic seen;
        reset_n = 1'b0; key_we = 1'b0; key_clear = 1'b0; key_addr = '0; key_data = '0;
        in_valid = 1'b0; in_block = '0; out_ready = 1'b0; rk_idx = '0;
        build_sbox();

        vecs[0] = '{KC1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
        vecs[1] = '{KB,  128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};
        expand(KB);
        vecs[2] = '{KB,  128'h0, ref_dec(128'h0)};
        expand(KC1);
        vecs[3] = '{KC1, 128'hdeadbeef0123456789abcdeffedcba98, ref_dec(128'hdeadbeef0123456789abcdeffedcba98)};
        rkv[0] = '{4'd0,  KC1};
        rkv[1] = '{4'd1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
        rkv[2] = '{4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        rkv[3] = '{4'd11, 128'h0};
        rkv[4] = '{4'd15, 128'h0};

        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_keys_valid", keys_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_core_next", core_next, 1'b0);
        chk("rst_blocks_done", blocks_done, 16'd0);
        chk("rst_out_block", out_block, 128'h0);
        chk("rst_key0", core_round_key, 128'h0);
        reset_n = 1'b1;

        // keys 0..9 only, then clear colliding with key 10, then key 10 alone
        for (int unsigned i = 0; i < 10; i++) wr_key(4'(i), rks[i]);
        chk("partial_keys_valid", keys_valid, 1'b0);
        chk("partial_in_ready", in_ready, 1'b0);
        @(negedge clk); key_we = 1'b1; key_addr = 4'd10; key_data = rks[10]; key_clear = 1'b1;
        @(negedge clk); key_we = 1'b0; key_clear = 1'b0;
        for (int unsigned i = 0; i < 10; i++) wr_key(4'(i), rks[i]);
        chk("clear_prio_keys_valid", keys_valid, 1'b0);
        @(negedge clk); key_we = 1'b1; key_addr = 4'd10; key_data = rks[10];
        @(posedge clk); #1 chk("key10_keys_valid", keys_valid, 1'b1);
        @(negedge clk); key_we = 1'b0;
        chk("key10_in_ready", in_ready, 1'b1);

        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk); rk_ovr = 1'b1; rk_idx = rkv[i].idx;
            #1 chk($sformatf("rkey_read_%0d", rkv[i].idx), core_round_key, rkv[i].exp);
        end
        @(negedge clk); rk_ovr = 1'b0;

        for (int unsigned i = 0; i < 4; i++) begin
            if (i == 0 || vecs[i].key != vecs[i-1].key) load_keys(vecs[i].key);
            send($sformatf("vec%0d", i), vecs[i].ct);
            wait_out(lat);
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd53);
            recv($sformatf("vec%0d", i), vecs[i].pt);
        end
        chk("blocks_done_after_table", blocks_done, 16'(ndel));

        // illegal key writes: during WAIT and to index 12 while idle
        load_keys(KC1);
        send("wait_wr", vecs[0].ct);
        repeat (5) @(negedge clk);
        key_we = 1'b1; key_addr = 4'd3; key_data = '1;
        @(negedge clk); key_we = 1'b0;
        recv("wait_wr", vecs[0].pt);
        rk_ovr = 1'b1; rk_idx = 4'd3;
        #1 chk("key3_unchanged", core_round_key, rks[3]);
        rk_ovr = 1'b0;
        wr_key(4'd12, '1);
        chk("addr12_keys_valid", keys_valid, 1'b1);
        send("addr12", vecs[3].ct);
        recv("addr12", vecs[3].pt);

        // back-pressure: second result parks in WAIT until the output drains
        base = ndel;
        send("bp_a", vecs[0].ct);
        wait_out(lat);
        send("bp_b", vecs[3].ct);
        repeat (70) @(negedge clk);
        chk("bp_busy", busy, 1'b1);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_hold_block", out_block, vecs[0].pt);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_swap_valid", out_valid, 1'b1);
        chk("bp_swap_block", out_block, vecs[3].pt);
        chk("bp_swap_idle", busy, 1'b0);
        @(negedge clk); out_ready = 1'b0;
        chk("bp_drained", out_valid, 1'b0);
        ndel += 2;
        chk("bp_blocks_done", blocks_done, 16'(base + 2));

        // 4-bit counter wraps on the 16th delivery
        while (ndel < 16) begin
            send("wrap", vecs[0].ct);
            recv("wrap", vecs[0].pt);
            if (ndel == 15) chk("wrap_cnt4_15", blocks_done4, 4'd15);
        end
        chk("wrap_cnt4_0", blocks_done4, 4'd0);
        chk("wrap_cnt16", blocks_done, 16'd16);

        // reset mid-decryption
        send("rst_mid", vecs[0].ct);
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_keys_valid", keys_valid, 1'b0);
        chk("mid_rst_blocks_done", blocks_done, 16'd0);
        chk("mid_rst_busy", busy, 1'b0);
        @(negedge clk); reset_n = 1'b1;
        seen = 1'b0;
        repeat (80) begin @(negedge clk); seen = seen | out_valid | busy; end
        chk("mid_rst_no_output", seen, 1'b0);
        chk("mid_rst_out_block", out_block, 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/aes_decipher_ctrl.md
AES_DECIPHER_CTRL -- requirements
Module: aes_decipher_ctrl

Interface
REQ-001 SHALL provide parameter NUM_RKEYS, default 11, meaning number of stored AES-128 round keys (indices 0..10).
REQ-002 SHALL provide parameter CNT_W, default 16, meaning width of the completed-block counter.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 key_we  in  1  round-key write strobe.
REQ-006 key_addr  in  4  round-key index.
REQ-007 key_data  in  128  round-key value.
REQ-008 key_clear  in  1  invalidates all stored round keys.
REQ-009 keys_valid  out  1  all NUM_RKEYS keys written since reset/clear.
REQ-010 in_valid / in_ready / in_block  in / out / in  1/1/128  ciphertext valid-ready input.
REQ-011 out_valid / out_ready / out_block  out / in / out  1/1/128  plaintext valid-ready output.
REQ-012 core_next  out  1  start pulse to decipher core.
REQ-013 core_block  out  128  ciphertext to core.
REQ-014 core_round  in  4  core round index.
REQ-015 core_round_key  out  128  key for core_round.
REQ-016 core_ready / core_new_block  in / in  1/128  core idle flag / core result.
REQ-017 busy  out  1  FSM not in IDLE.
REQ-018 blocks_done  out  CNT_W  count of blocks delivered on output handshake.

Function
REQ-019 FSM states SHALL be IDLE, START, WAIT: IDLE->START on in_valid&&in_ready; START->WAIT unconditionally; WAIT->IDLE when the result is captured.
REQ-020 in_ready SHALL be 1 only in IDLE with keys_valid=1 and core_ready=1.
REQ-021 On input handshake, in_block SHALL be latched into a holding register driving core_block, stable until the next handshake.
REQ-022 core_next SHALL be 1 for exactly the single cycle in START, 0 otherwise.
REQ-023 In WAIT, result SHALL be captured into out_block, with out_valid set, on the first cycle where core_ready=1 and (out_valid=0 or out_ready=1).
REQ-024 If core_ready=1 in WAIT but the output register is occupied and out_ready=0, the FSM SHALL remain in WAIT (core holds its result).
REQ-025 out_valid SHALL stay 1 with out_block stable until out_ready=1; simultaneous drain and capture SHALL load the new block with out_valid kept 1.
REQ-026 Latency SHALL be 53 cycles from the input-handshake edge to out_valid=1 with an empty output register (1 START + 52 core cycles).
REQ-027 core_round_key SHALL equal stored key[core_round] combinationally; core_round > 10 SHALL yield 128'h0.
REQ-028 key_we SHALL write key_data to key[key_addr] and set mask bit key_addr only when FSM is IDLE and key_addr <= 10; otherwise the write is ignored.
REQ-029 keys_valid SHALL equal AND of the 11-bit written mask; key_clear SHALL zero the mask and has priority over a same-cycle key_we.
REQ-030 key_clear SHALL NOT abort an in-flight block; it only blocks new acceptance.
REQ-031 blocks_done SHALL increment by 1 per out_valid&&out_ready and wrap from all-ones to 0.

Reset
REQ-032 On reset_n=0: FSM=IDLE, key mask=0, key storage=0, holding register=0, out_block=0, out_valid=0, blocks_done=0, core_next=0, busy=0, in_ready=0 (keys_valid=0).
REQ-033 Reset asserted mid-operation SHALL discard the in-flight block and output data with no output handshake afterward until a new input is accepted.

Structure
REQ-034 Shared package aes_ctrl_pkg SHALL hold FSM state encodings, AES128_ROUNDS=10, NUM_RKEYS=11, DEC_LATENCY=53.
REQ-035 Round-key storage and mask SHALL be a sub-module aes_rkey_store (write port, combinational read port, valid flag).
REQ-036 The decipher core SHALL NOT be instantiated inside this block; the bench connects it externally.

Verification
REQ-037 FIPS-197 C.1 round keys loaded, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> out_block 00112233445566778899aabbccddeeff, out_valid exactly 53 cycles after handshake.
REQ-038 Keys 0..9 only written -> keys_valid=0, in_ready=0; write key 10 -> keys_valid=1 next cycle.
REQ-039 out_ready held 0 while two blocks submitted -> second stays in WAIT; out_ready=1 -> both delivered in order, blocks_done=2.
REQ-040 key_we to index 3 during WAIT and key_addr=12 in IDLE -> stored keys unchanged, result still correct.
REQ-041 reset_n pulsed low at cycle 20 of a decryption -> out_valid=0, keys_valid=0, blocks_done=0, no output ever produced.
REQ-042 blocks_done preloaded near wrap via 2^CNT_W handshakes (CNT_W=4 build) -> count wraps 15->0.
